// File: rtl/multiplier_multicycle_param.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_multicycle_param
// Description : Iterative shift-add integer multiplier for the execute-stage
//               ALU. Supports MUL / MULH / MULHSU / MULHU / MULW, a
//               valid/ready request handshake, a one-cycle done pulse and a
//               flush input that abandons an in-flight operation.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous active-high reset
//               valid  - request, accepted when valid && ready && !flush
//               flush  - abandon in-flight operation / block acceptance
//               op     - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 MUL
//               a, b   - operands, sampled only at acceptance
//               ready  - high in IDLE
//               busy   - high while iterating or fixing up the result
//               done   - one-cycle pulse, c valid in that cycle
//               c      - result, held until the next completed operation
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_multicycle_param #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_MULW   = 3'd4;

    localparam logic [CW-1:0] c_FULL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] c_HALF_CNT = CW'(HALF);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [2:0]         r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH:0]   r_prod;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_c;

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance
    // ------------------------------------------------------------------
    logic               w_is_w;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_is_w     = (op == c_OP_MULW);
    assign w_a_signed = (op == c_OP_MULH) || (op == c_OP_MULHSU);
    assign w_b_signed = (op == c_OP_MULH);
    assign w_neg_a    = w_a_signed && a[WIDTH-1];
    assign w_neg_b    = w_b_signed && b[WIDTH-1];

    // Word mode multiplies the low halves as unsigned values; the low half of
    // the product is the same whatever signedness is assumed.
    assign w_opa   = w_is_w ? {{(WIDTH-HALF){1'b0}}, a[HALF-1:0]} : a;
    assign w_opb   = w_is_w ? {{(WIDTH-HALF){1'b0}}, b[HALF-1:0]} : b;
    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct unsigned magnitude.
    assign w_mag_a = w_neg_a ? -a : w_opa;
    assign w_mag_b = w_neg_b ? -b : w_opb;

    // ------------------------------------------------------------------
    // Iteration and result fix-up
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_full;
    logic [WIDTH-1:0]   w_result;

    assign w_sum   = r_prod[2*WIDTH:WIDTH] + {1'b0, r_mag_b};
    assign w_upper = r_prod[0] ? w_sum : r_prod[2*WIDTH:WIDTH];
    assign w_full  = r_neg ? -r_prod[2*WIDTH-1:0] : r_prod[2*WIDTH-1:0];

    always_comb begin
        w_result = w_full[WIDTH-1:0];
        case (r_op)
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_result = w_full[2*WIDTH-1:WIDTH];
            // After only HALF shifts the HALF-bit product sits one half-word
            // higher than in full mode, so its low half is P[WIDTH-1:HALF].
            c_OP_MULW: w_result = {{(WIDTH-HALF){r_prod[WIDTH-1]}}, r_prod[WIDTH-1:HALF]};
            default:   w_result = w_full[WIDTH-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (valid && !flush) w_next = c_ST_BUSY;
            c_ST_BUSY: begin
                if (flush) begin
                    w_next = c_ST_IDLE;
                end else if (r_cnt == c_CNT_ONE) begin
                    w_next = c_ST_FIX;
                end
            end
            c_ST_FIX:  w_next = flush ? c_ST_IDLE : c_ST_DONE;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (r_state)
            c_ST_IDLE: ready = 1'b1;
            c_ST_BUSY: busy  = 1'b1;
            c_ST_FIX:  busy  = 1'b1;
            c_ST_DONE: done  = 1'b1;
            default:   ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= 3'd0;
            r_neg   <= 1'b0;
            r_mag_b <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (valid && !flush) begin
                        r_op    <= op;
                        r_neg   <= w_neg_a ^ w_neg_b;
                        r_mag_b <= w_mag_b;
                        r_prod  <= {{(WIDTH+1){1'b0}}, w_mag_a};
                        r_cnt   <= w_is_w ? c_HALF_CNT : c_FULL_CNT;
                    end
                end
                c_ST_BUSY: begin
                    if (!flush) begin
                        r_prod <= {1'b0, w_upper, r_prod[WIDTH-1:1]};
                        r_cnt  <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ST_FIX: begin
                    if (!flush) begin
                        r_c <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c = r_c;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_multicycle_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_multicycle_param
// Description : Self-checking bench for multiplier_multicycle_param with a
//               64-bit and a 16-bit instance, randomized operations checked
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_multicycle_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        m_valid, m_flush;
    logic [2:0]  m_op;
    logic [63:0] m_a, m_b;
    logic        m_ready, m_busy, m_done;
    logic [63:0] m_c;

    logic        s_valid, s_flush;
    logic [2:0]  s_op;
    logic [15:0] s_a, s_b;
    logic        s_ready, s_busy, s_done;
    logic [15:0] s_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_exp;

    multiplier_multicycle_param #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .valid(m_valid), .flush(m_flush), .op(m_op),
        .a(m_a), .b(m_b), .ready(m_ready), .busy(m_busy), .done(m_done), .c(m_c)
    );

    multiplier_multicycle_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .valid(s_valid), .flush(s_flush), .op(s_op),
        .a(s_a), .b(s_b), .ready(s_ready), .busy(s_busy), .done(s_done), .c(s_c)
    );

    // Reference: treat operands as integers mod 2^128 and pick the result.
    function automatic logic [63:0] ref_mul(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ax, bx, p;
        logic [63:0]  wm, hm, lo;
        int h;
        h  = w / 2;
        wm = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        if (op == 3'd4) begin
            hm = (64'd1 << h) - 64'd1;
            p  = {64'd0, a & hm} * {64'd0, b & hm};
            lo = p[63:0] & hm;
            if (lo[h-1]) lo = lo | ~hm;
            return lo & wm;
        end
        ax = {64'd0, a & wm};
        bx = {64'd0, b & wm};
        if ((op == 3'd1 || op == 3'd2) && a[w-1]) ax = ax - (128'd1 << w);
        if (op == 3'd1 && b[w-1]) bx = bx - (128'd1 << w);
        p = ax * bx;
        if (op == 3'd1 || op == 3'd2 || op == 3'd3) p = p >> w;
        return p[63:0] & wm;
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 4))
            0: return {$urandom, $urandom};
            1: return 64'd0;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            default: return 64'($urandom_range(0, 255));
        endcase
    endfunction

    // Issue one op on the 64-bit instance in the current cycle k; returns the
    // result at done, cycles from accept to done (0 on timeout), whether ready
    // stayed low k+1..done, and ready in the cycle after done.
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat,
                         output bit rdy_low, output bit rdy_after);
        res = '0; lat = 0; rdy_low = 1'b1;
        m_op = op; m_a = a; m_b = b; m_valid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                m_valid = 1'b0;
                m_op = 3'($urandom); m_a = {$urandom, $urandom}; m_b = {$urandom, $urandom};
            end
            if (m_ready) rdy_low = 1'b0;
            if (m_done) begin
                lat = i; res = m_c;
                break;
            end
        end
        @(posedge clk); #1;
        rdy_after = m_ready;
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output int lat);
        res = '0; lat = 0;
        s_op = op; s_a = a; s_b = b; s_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                s_valid = 1'b0;
                s_a = 16'($urandom); s_b = 16'($urandom);
            end
            if (s_done) begin
                lat = i; res = s_c;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", m_ready); end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        n_checks++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", m_done); end
        n_checks++; if (m_c !== 64'd0) begin n_fail++; $display("FAIL reset_c: got %h want 0", m_c); end
        n_checks++; if (s_c !== 16'd0) begin n_fail++; $display("FAIL reset_c16: got %h want 0", s_c); end
        last_exp = 64'd0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op[8];
        logic [63:0] t_a[8], t_b[8], t_c[8];
        logic [63:0] res;
        int lat;
        bit rl, ra;
        t_op[0] = 3'd0; t_a[0] = 64'd3;                  t_b[0] = 64'd5;                  t_c[0] = 64'd15;
        t_op[1] = 3'd1; t_a[1] = '1;                     t_b[1] = '1;                     t_c[1] = 64'd0;
        t_op[2] = 3'd3; t_a[2] = '1;                     t_b[2] = '1;                     t_c[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        t_op[3] = 3'd2; t_a[3] = '1;                     t_b[3] = '1;                     t_c[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        t_op[4] = 3'd0; t_a[4] = 64'h8000_0000_0000_0000; t_b[4] = '1;                    t_c[4] = 64'h8000_0000_0000_0000;
        t_op[5] = 3'd1; t_a[5] = 64'h8000_0000_0000_0000; t_b[5] = '1;                    t_c[5] = 64'd0;
        t_op[6] = 3'd4; t_a[6] = 64'h7FFF_FFFF;          t_b[6] = 64'd2;                  t_c[6] = 64'hFFFF_FFFF_FFFF_FFFE;
        t_op[7] = 3'd4; t_a[7] = 64'hDEAD_BEEF_7FFF_FFFF; t_b[7] = 64'h1234_5678_0000_0002; t_c[7] = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 8; i++) begin
            run64(t_op[i], t_a[i], t_b[i], res, lat, rl, ra);
            n_checks++; if (res !== t_c[i]) begin n_fail++; $display("FAIL directed_c[%0d]: got %h want %h", i, res, t_c[i]); end
            n_checks++; if (lat != ((t_op[i] == 3'd4) ? 34 : 66)) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, (t_op[i] == 3'd4) ? 34 : 66); end
            n_checks++; if (rl !== 1'b1) begin n_fail++; $display("FAIL directed_ready_low[%0d]: got %b want 1", i, rl); end
            n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL directed_ready_after[%0d]: got %b want 1", i, ra); end
            last_exp = t_c[i];
        end
    endtask

    // Each op issued in the cycle right after the previous one's ready check.
    task automatic test_random_back_to_back();
        logic [2:0]  op;
        logic [63:0] a, b, exp, res;
        int lat;
        bit rl, ra;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick64(); b = pick64();
            exp = ref_mul(64, op, a, b);
            run64(op, a, b, res, lat, rl, ra);
            n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random_c op=%0d a=%h b=%h: got %h want %h", op, a, b, res, exp); end
            n_checks++; if (lat != ((op == 3'd4) ? 34 : 66)) begin n_fail++; $display("FAIL random_latency op=%0d: got %0d want %0d", op, lat, (op == 3'd4) ? 34 : 66); end
            n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL random_ready_after: got %b want 1", ra); end
            last_exp = exp;
        end
    endtask

    task automatic test_flush();
        logic [63:0] a, b, exp, res;
        int lat;
        bit rl, ra, seen;
        seen = 1'b0;
        m_op = 3'd0; m_a = 64'd1234567; m_b = 64'd7654321; m_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            m_valid = (i == 5);
            if (i == 5) begin m_op = 3'd3; m_a = '1; m_b = '1; end
            if (m_done) seen = 1'b1;
        end
        m_flush = 1'b1;
        @(posedge clk); #1;
        m_flush = 1'b0;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", m_ready); end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", m_busy); end
        n_checks++; if (m_c !== last_exp) begin n_fail++; $display("FAIL flush_c_held: got %h want %h", m_c, last_exp); end
        repeat (60) begin
            @(posedge clk); #1;
            if (m_done) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_done: got %b want 0", seen); end
        // flush together with valid in IDLE must block acceptance
        m_valid = 1'b1; m_flush = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_flush = 1'b0;
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_blocks: got busy %b want 0", m_busy); end
        a = pick64(); b = pick64();
        exp = ref_mul(64, 3'd1, a, b);
        run64(3'd1, a, b, res, lat, rl, ra);
        n_checks++; if (res !== exp) begin n_fail++; $display("FAIL flush_next_op: got %h want %h", res, exp); end
        n_checks++; if (lat != 66) begin n_fail++; $display("FAIL flush_next_latency: got %0d want 66", lat); end
        last_exp = exp;
    endtask

    task automatic test_reset_mid();
        m_op = 3'd3; m_a = '1; m_b = 64'd12345; m_valid = 1'b1;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            m_valid = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", m_ready); end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", m_busy); end
        n_checks++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", m_done); end
        n_checks++; if (m_c !== 64'd0) begin n_fail++; $display("FAIL midreset_c: got %h want 0", m_c); end
        last_exp = 64'd0;
    endtask

    task automatic test_width16();
        logic [2:0]  op;
        logic [15:0] a, b, res;
        logic [63:0] exp;
        int lat;
        run16(3'd3, 16'hFFFF, 16'hFFFF, res, lat);
        n_checks++; if (res !== 16'hFFFE) begin n_fail++; $display("FAIL w16_mulhu_c: got %h want fffe", res); end
        n_checks++; if (lat != 18) begin n_fail++; $display("FAIL w16_mulhu_latency: got %0d want 18", lat); end
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom); b = 16'($urandom);
            if (i % 4 == 0) a = 16'h8000;
            exp = ref_mul(16, op, {48'd0, a}, {48'd0, b});
            run16(op, a, b, res, lat);
            n_checks++; if (res !== exp[15:0]) begin n_fail++; $display("FAIL w16_random_c op=%0d a=%h b=%h: got %h want %h", op, a, b, res, exp[15:0]); end
            n_checks++; if (lat != ((op == 3'd4) ? 10 : 18)) begin n_fail++; $display("FAIL w16_random_latency op=%0d: got %0d want %0d", op, lat, (op == 3'd4) ? 10 : 18); end
        end
    endtask

    initial begin
        reset = 1'b1;
        m_valid = 1'b0; m_flush = 1'b0; m_op = 3'd0; m_a = '0; m_b = '0;
        s_valid = 1'b0; s_flush = 1'b0; s_op = 3'd0; s_a = '0; s_b = '0;
        last_exp = 64'd0;
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_flush();
        test_reset_mid();
        test_width16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
